// File: rtl/bitstream_word_buffer.sv
// Byte-to-16-bit word packer feeding a show-ahead FIFO for the CAVLC decoder.
// Define EPB_STRIP_EN to drop H.264 emulation-prevention bytes (00 00 03 -> 00 00).
module bitstream_word_buffer #(
    parameter int DEPTH = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [7:0]        ByteIn,
    input  logic              ByteValid,
    output logic              ByteReady,
    input  logic              Flush,
    input  logic              RdReq,
    output logic [15:0]       Bitstream,
    output logic              WordValid,
    output logic [ADDR_W:0]   Level,
    output logic              Underflow,
    output logic              EpbDrop
);

    localparam logic [1:0] EMPTY_HI   = 2'd0;
    localparam logic [1:0] HALF       = 2'd1;
    localparam logic [1:0] FLUSH_WAIT = 2'd2;

    localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(DEPTH);

    logic [1:0]        state_reg, state_next;
    logic [7:0]        hi_byte_reg, hi_byte_next;
    logic [ADDR_W-1:0] rd_ptr_reg, wr_ptr_reg;
    logic [ADDR_W:0]   level_reg;
    logic              underflow_reg;
    logic [15:0]       mem [DEPTH];

    logic              hi_valid;
    logic              full;
    logic              word_valid;
    logic              byte_ready;
    logic              byte_accept;
    logic              byte_pack;
    logic              push;
    logic              pop;
    logic [15:0]       push_word;

    always_comb begin
        hi_valid    = (state_reg != EMPTY_HI);
        full        = (level_reg == FULL_LEVEL);
        word_valid  = (level_reg != '0);
        // Readiness depends only on registered state; a same-cycle pop does not help.
        byte_ready  = !(hi_valid && full) && (state_reg != FLUSH_WAIT);
        byte_accept = ByteValid && byte_ready;
        pop         = RdReq && word_valid;
    end

`ifdef EPB_STRIP_EN
    logic [1:0] zero_run_reg, zero_run_next;
    logic       epb_hit;
    logic       epb_drop_reg;

    always_comb begin
        epb_hit       = byte_accept && (ByteIn == 8'h03) && (zero_run_reg == 2'd2);
        zero_run_next = zero_run_reg;
        if (byte_accept) begin
            if (epb_hit) begin
                zero_run_next = 2'd0;
            end else if (ByteIn == 8'h00) begin
                zero_run_next = (zero_run_reg == 2'd2) ? 2'd2 : zero_run_reg + 2'd1;
            end else begin
                zero_run_next = 2'd0;
            end
        end
        // End of slice breaks any zero run, even one built by a byte in this cycle.
        if (Flush) begin
            zero_run_next = 2'd0;
        end
        byte_pack = byte_accept && !epb_hit;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            zero_run_reg <= 2'd0;
            epb_drop_reg <= 1'b0;
        end else begin
            zero_run_reg <= zero_run_next;
            epb_drop_reg <= epb_hit;
        end
    end

    assign EpbDrop = epb_drop_reg;
`else
    always_comb begin
        byte_pack = byte_accept;
    end

    assign EpbDrop = 1'b0;
`endif

    // The byte is processed first; a same-cycle Flush then acts on the resulting state.
    always_comb begin
        state_next   = state_reg;
        hi_byte_next = hi_byte_reg;
        push         = 1'b0;
        push_word    = 16'h0000;
        case (state_reg)
            EMPTY_HI: begin
                if (byte_pack) begin
                    hi_byte_next = ByteIn;
                    if (Flush) begin
                        if (!full) begin
                            push      = 1'b1;
                            push_word = {ByteIn, 8'h00};
                        end else begin
                            state_next = FLUSH_WAIT;
                        end
                    end else begin
                        state_next = HALF;
                    end
                end
            end
            HALF: begin
                if (byte_pack) begin
                    push       = 1'b1;
                    push_word  = {hi_byte_reg, ByteIn};
                    state_next = EMPTY_HI;
                end else if (Flush) begin
                    if (!full) begin
                        push       = 1'b1;
                        push_word  = {hi_byte_reg, 8'h00};
                        state_next = EMPTY_HI;
                    end else begin
                        state_next = FLUSH_WAIT;
                    end
                end
            end
            FLUSH_WAIT: begin
                if (!full) begin
                    push       = 1'b1;
                    push_word  = {hi_byte_reg, 8'h00};
                    state_next = EMPTY_HI;
                end
            end
            default: begin
                state_next = EMPTY_HI;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg     <= EMPTY_HI;
            hi_byte_reg   <= 8'h00;
            rd_ptr_reg    <= '0;
            wr_ptr_reg    <= '0;
            level_reg     <= '0;
            underflow_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            hi_byte_reg <= hi_byte_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
            if (RdReq && !word_valid) begin
                underflow_reg <= 1'b1;
            end
        end
    end

    // Storage needs no reset: the head is masked until a word has been written.
    always_ff @(posedge Clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_word;
        end
    end

    assign ByteReady = byte_ready;
    assign WordValid = word_valid;
    assign Bitstream = word_valid ? mem[rd_ptr_reg] : 16'h0000;
    assign Level     = level_reg;
    assign Underflow = underflow_reg;

endmodule

// File: tb/tb_bitstream_word_buffer.sv
// Randomised and directed checks of bitstream_word_buffer against a queue-based byte-stream model.
module tb_bitstream_word_buffer;

    localparam int DEPTH = 8;

    logic        Clk;
    logic        Reset;
    logic [7:0]  ByteIn;
    logic        ByteValid;
    logic        ByteReady;
    logic        Flush;
    logic        RdReq;
    logic [15:0] Bitstream;
    logic        WordValid;
    logic [3:0]  Level;
    logic        Underflow;
    logic        EpbDrop;

    int n_checks = 0;
    int n_fail   = 0;

    bitstream_word_buffer #(.DEPTH(DEPTH)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .ByteIn    (ByteIn),
        .ByteValid (ByteValid),
        .ByteReady (ByteReady),
        .Flush     (Flush),
        .RdReq     (RdReq),
        .Bitstream (Bitstream),
        .WordValid (WordValid),
        .Level     (Level),
        .Underflow (Underflow),
        .EpbDrop   (EpbDrop)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Reference model: completed words in a queue, plus the pending odd byte.
    logic [15:0] mq[$];
    bit          m_has_hi;
    logic [7:0]  m_hi;
    bit          m_fw;
    int          m_zr;
    bit          m_under;
    bit          m_epb;

    function automatic bit exp_ready();
        return !(m_has_hi && (mq.size() == DEPTH)) && !m_fw;
    endfunction

    function automatic logic [23:0] exp_vec();
        logic [15:0] head;
        logic        wv;
        logic [3:0]  lvl;
        wv   = (mq.size() > 0);
        head = wv ? mq[0] : 16'h0000;
        lvl  = 4'(mq.size());
        return {head, wv, lvl, exp_ready(), m_under, m_epb};
    endfunction

    function automatic logic [23:0] obs_vec();
        return {Bitstream, WordValid, Level, ByteReady, Underflow, EpbDrop};
    endfunction

    // Drive one cycle of inputs, advance the model over the clock edge, settle.
    task automatic step(input bit v, input logic [7:0] b, input bit fl, input bit rd, input bit rs);
        bit full;
        bit ready;
        bit acc;
        bit drop;
        ByteValid = v;
        ByteIn    = b;
        Flush     = fl;
        RdReq     = rd;
        Reset     = rs;
        full  = (mq.size() == DEPTH);
        ready = exp_ready();
        @(posedge Clk);
        drop = 1'b0;
        if (rs) begin
            mq.delete();
            m_has_hi = 1'b0;
            m_fw     = 1'b0;
            m_zr     = 0;
            m_under  = 1'b0;
        end else begin
            acc = v && ready;
            if (rd) begin
                if (mq.size() > 0) void'(mq.pop_front());
                else m_under = 1'b1;
            end
            if (m_fw) begin
                if (!full) begin
                    mq.push_back({m_hi, 8'h00});
                    m_fw     = 1'b0;
                    m_has_hi = 1'b0;
                end
            end else begin
                if (acc) begin
`ifdef EPB_STRIP_EN
                    drop = (b == 8'h03) && (m_zr == 2);
                    if (drop) m_zr = 0;
                    else if (b == 8'h00) m_zr = (m_zr < 2) ? m_zr + 1 : 2;
                    else m_zr = 0;
`endif
                    if (!drop) begin
                        if (m_has_hi) begin
                            mq.push_back({m_hi, b});
                            m_has_hi = 1'b0;
                        end else begin
                            m_hi     = b;
                            m_has_hi = 1'b1;
                        end
                    end
                end
                if (fl) begin
                    m_zr = 0;
                    if (m_has_hi) begin
                        if (!full) begin
                            mq.push_back({m_hi, 8'h00});
                            m_has_hi = 1'b0;
                        end else begin
                            m_fw = 1'b1;
                        end
                    end
                end
            end
        end
        m_epb = drop;
        #1;
    endtask

    task automatic test_reset();
        step(0, 8'h00, 0, 0, 1);
        step(0, 8'h00, 0, 0, 1);
        step(0, 8'h00, 0, 0, 0);
        n_checks++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_model: got %h want %h", obs_vec(), exp_vec());
        end
        n_checks++;
        if ({Level, WordValid, Bitstream, ByteReady, Underflow, EpbDrop} !== {4'd0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: lvl=%0d wv=%b bs=%h rdy=%b uf=%b epb=%b", Level, WordValid, Bitstream, ByteReady, Underflow, EpbDrop);
        end
    endtask

    task automatic test_pack();
        step(1, 8'h12, 0, 0, 0);
        n_checks++;
        if (WordValid !== 1'b0) begin
            n_fail++;
            $display("FAIL pack_half_wv: got %b want 0", WordValid);
        end
        step(1, 8'h34, 0, 0, 0);
        n_checks++;
        if ({WordValid, Bitstream} !== {1'b1, 16'h1234}) begin
            n_fail++;
            $display("FAIL pack_first_word: got wv=%b bs=%h want wv=1 bs=1234", WordValid, Bitstream);
        end
        step(1, 8'h56, 0, 0, 0);
        step(1, 8'h78, 0, 0, 0);
        n_checks++;
        if (Level !== 4'd2) begin
            n_fail++;
            $display("FAIL pack_level: got %0d want 2", Level);
        end
        for (int i = 0; i < 2; i++) begin
            step(0, 8'h00, 0, 1, 0);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL pack_drain: got %h want %h", obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_epb();
        logic [7:0]  bytes [6];
        logic [15:0] want  [3];
        int          pulses;
        bytes = '{8'h00, 8'h00, 8'h03, 8'h01, 8'h02, 8'h03};
`ifdef EPB_STRIP_EN
        want = '{16'h0000, 16'h0102, 16'h0300};
`else
        want = '{16'h0000, 16'h0301, 16'h0203};
`endif
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step(1, bytes[i], 0, 0, 0);
            pulses += int'(EpbDrop);
        end
        step(0, 8'h00, 1, 0, 0);
        pulses += int'(EpbDrop);
        step(0, 8'h00, 0, 0, 0);
        pulses += int'(EpbDrop);
        n_checks++;
`ifdef EPB_STRIP_EN
        if (pulses != 1) begin
`else
        if (pulses != 0) begin
`endif
            n_fail++;
            $display("FAIL epb_pulses: got %0d", pulses);
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (Bitstream !== want[i]) begin
                n_fail++;
                $display("FAIL epb_word%0d: got %h want %h", i, Bitstream, want[i]);
            end
            step(0, 8'h00, 0, 1, 0);
        end
        n_checks++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL epb_drained: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 17; i++) begin
            step(1, 8'(8'h10 + i), 0, 0, 0);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL full_fill%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        n_checks++;
        if ({Level, ByteReady} !== {4'd8, 1'b0}) begin
            n_fail++;
            $display("FAIL full_block: got lvl=%0d rdy=%b want lvl=8 rdy=0", Level, ByteReady);
        end
        step(0, 8'h00, 0, 1, 0);
        n_checks++;
        if ({Level, ByteReady} !== {4'd7, 1'b1}) begin
            n_fail++;
            $display("FAIL full_after_pop: got lvl=%0d rdy=%b want lvl=7 rdy=1", Level, ByteReady);
        end
        step(1, 8'h22, 0, 0, 0);
        n_checks++;
        if ({Level, ByteReady} !== {4'd8, 1'b1} || mq[DEPTH-1] !== 16'h2022) begin
            n_fail++;
            $display("FAIL full_word9: got lvl=%0d rdy=%b want lvl=8 rdy=1", Level, ByteReady);
        end
    endtask

    task automatic test_flush_wait();
        step(1, 8'hAB, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        n_checks++;
        if ({Level, ByteReady} !== {4'd8, 1'b0}) begin
            n_fail++;
            $display("FAIL fw_enter: got lvl=%0d rdy=%b want lvl=8 rdy=0", Level, ByteReady);
        end
        step(1, 8'h55, 0, 1, 0);
        n_checks++;
        if ({Level, ByteReady} !== {4'd7, 1'b0}) begin
            n_fail++;
            $display("FAIL fw_pop: got lvl=%0d rdy=%b want lvl=7 rdy=0", Level, ByteReady);
        end
        step(0, 8'h00, 0, 0, 0);
        n_checks++;
        if ({Level, ByteReady} !== {4'd8, 1'b1}) begin
            n_fail++;
            $display("FAIL fw_write: got lvl=%0d rdy=%b want lvl=8 rdy=1", Level, ByteReady);
        end
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL fw_drain%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            if (i == DEPTH - 1) begin
                n_checks++;
                if (Bitstream !== 16'hAB00) begin
                    n_fail++;
                    $display("FAIL fw_padded: got %h want ab00", Bitstream);
                end
            end
            step(0, 8'h00, 0, 1, 0);
        end
    endtask

    task automatic test_underflow();
        step(0, 8'h00, 0, 1, 0);
        n_checks++;
        if ({Underflow, Level, Bitstream} !== {1'b1, 4'd0, 16'h0000}) begin
            n_fail++;
            $display("FAIL uf_set: got uf=%b lvl=%0d bs=%h want uf=1 lvl=0 bs=0000", Underflow, Level, Bitstream);
        end
        step(1, 8'hC1, 0, 0, 0);
        step(1, 8'hC2, 0, 0, 0);
        n_checks++;
        if ({Underflow, Level, Bitstream} !== {1'b1, 4'd1, 16'hC1C2}) begin
            n_fail++;
            $display("FAIL uf_sticky: got uf=%b lvl=%0d bs=%h want uf=1 lvl=1 bs=c1c2", Underflow, Level, Bitstream);
        end
        step(0, 8'h00, 0, 1, 0);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 7; i++) step(1, 8'(8'h41 + i), 0, 0, 0);
        n_checks++;
        if ({Level, ByteReady} !== {4'd3, 1'b1}) begin
            n_fail++;
            $display("FAIL rst_pre: got lvl=%0d rdy=%b want lvl=3 rdy=1", Level, ByteReady);
        end
        step(1, 8'h99, 0, 1, 1);
        n_checks++;
        if ({Level, WordValid, Bitstream, ByteReady, Underflow} !== {4'd0, 1'b0, 16'h0000, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL rst_mid: got lvl=%0d wv=%b bs=%h rdy=%b uf=%b", Level, WordValid, Bitstream, ByteReady, Underflow);
        end
        step(1, 8'h5A, 0, 0, 0);
        step(1, 8'hA5, 0, 0, 0);
        n_checks++;
        if ({Level, Bitstream} !== {4'd1, 16'h5AA5}) begin
            n_fail++;
            $display("FAIL rst_first_word: got lvl=%0d bs=%h want lvl=1 bs=5aa5", Level, Bitstream);
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        bit v, fl, rd, rs;
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0, 1:    b = 8'h00;
                2:       b = 8'h03;
                default: b = 8'($urandom);
            endcase
            v  = ($urandom_range(0, 9) < 7);
            rd = ($urandom_range(0, 9) < 4);
            fl = ($urandom_range(0, 19) == 0);
            rs = ($urandom_range(0, 199) == 0);
            step(v, b, fl, rd, rs);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_cycle%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        ByteIn    = 8'h00;
        ByteValid = 1'b0;
        Flush     = 1'b0;
        RdReq     = 1'b0;
        Reset     = 1'b1;
        m_has_hi  = 1'b0;
        m_hi      = 8'h00;
        m_fw      = 1'b0;
        m_zr      = 0;
        m_under   = 1'b0;
        m_epb     = 1'b0;
        test_reset();
        test_pack();
        test_epb();
        test_full();
        test_flush_wait();
        test_underflow();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
